stage_sequencer: RTL and testbench
==================================

# stage_sequencer

Registered run controller for the per-packet processing chain that shares the single node memory. It replaces the combinational done-flag priority chain with an explicit FSM that:
- starts each stage with a one-cycle pulse and waits for its done;
- drives the memory address/data-in and write-enable mux selects;
- gates write enable for stages that must never write;
- ends a run early on a stage's abort condition or on a watchdog timeout.

It sits between the run trigger `en` and the stage modules, from learnCosts (stage 0) to selectMyAction (stage 7).

## Interface
Parameters:
- NUM_STAGES, 8, number of chained stages; stage i owns mux input i.
- SEL_W, 3, width of mux selects and stage index.
- TIMEOUT, 2000, maximum WAIT cycles per stage before watchdog abort.
- WRITE_MASK, 8'b1010_1111, bit i = 1 if stage i may write memory (stages 4 and 6 are read-only).

Ports:
- clock  in  1  system clock, rising edge.
- nrst  in  1  reset, synchronous, active-low.
- en  in  1  run request; sampled only in IDLE.
- stage_done  in  NUM_STAGES  level done flag from each stage; held until that stage is cleared.
- abort_req  in  NUM_STAGES  per-stage early-exit condition (forAggregation, !iamForwarding, ...); valid while matching stage_done is high.
- stage_start  out  NUM_STAGES  one-hot, single-cycle start pulse.
- stage_clr  out  1  one-cycle synchronous clear to all stages at run end.
- addr_select  out  SEL_W  address / mem_data_in mux select = current stage index.
- wr_select  out  SEL_W  write-enable mux select = current stage index.
- wr_allow  out  1  AND-gate for memory wr_en.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse: all stages completed.
- aborted  out  1  one-cycle pulse: run ended by abort_req.
- timeout  out  1  one-cycle pulse: run ended by watchdog.
- end_stage  out  SEL_W  index of the last stage of the previous run; held until the next run ends.
- run_count  out  16  completed (done) runs; wraps 0xFFFF→0; aborted and timed-out runs are not counted.

## Operation
- States: IDLE, START, WAIT, CLEAR. Outputs are Moore-decoded from registered state/idx/end-cause.
- IDLE:
  - en=1 → START with idx←0.
  - Otherwise stay in IDLE.
- START (exactly 1 cycle):
  - stage_start[idx]=1; watchdog←0.
  - → WAIT.
- WAIT: watchdog increments each cycle. Priority of exits, evaluated at each edge:
  - stage_done[idx]=1 and abort_req[idx]=1 → CLEAR with cause=ABORT, end_stage←idx.
  - stage_done[idx]=1, idx=NUM_STAGES-1 → CLEAR with cause=DONE, end_stage←idx, run_count+1.
  - stage_done[idx]=1, otherwise → START with idx+1.
  - Watchdog = TIMEOUT-1 and stage_done[idx]=0 → CLEAR with cause=TIMEOUT, end_stage←idx.
- CLEAR (exactly 1 cycle):
  - stage_clr=1; exactly one of done/aborted/timeout=1 per cause.
  - → IDLE.
- addr_select and wr_select equal idx in START and WAIT; they are 0 in IDLE and CLEAR.
- wr_allow=WRITE_MASK[idx] in START and WAIT; 0 in IDLE and CLEAR.
- stage_done and abort_req bits of non-current stages are ignored.
- stage_done[idx] is not sampled in START, so a stale done from an uncleared stage cannot skip a stage.
- en while busy is ignored; no queuing.

## Timing
- Reset (nrst=0 at an edge): state=IDLE, idx=0, watchdog=0, run_count=0, end_stage=0. All pulse outputs, stage_start, stage_clr, busy, wr_allow, addr_select and wr_select = 0.
- Reset mid-run aborts immediately. No stage_clr or end-of-run pulse is emitted; stages are reset by their own nrst.
- Latency, measured from the edge sampling en=1 to the edge ending CLEAR: Σ(1 + w_i) + 1 cycles, where w_i = WAIT cycles of stage i including the one where done is sampled. Minimum per stage = 2 cycles.
- Back-to-back runs: en held high gives one IDLE cycle between CLEAR and the next START.
- Done and watchdog expiry on the same edge: done wins.
- Watchdog width: ceil(log2(TIMEOUT)) bits; it never wraps.

## Test plan
- Normal run: en pulse; each stage raises done 2 cycles after its start (w_i=2) → addr_select steps 0..7, one stage_start pulse per stage, done pulse at cycle 25 after en edge, run_count=1, end_stage=7.
- Abort: stage 1 raises done with abort_req[1]=1 → CLEAR follows, aborted=1, stage_clr=1, stage_start[2] never pulses, end_stage=1, run_count unchanged.
- Timeout: stage 4 never raises done, TIMEOUT=16 → timeout pulse after 16 WAIT cycles, end_stage=4, wr_allow=0 throughout stage 4 and 6 windows.
- Stale done: all stage_done held high from start → each stage still takes exactly 2 cycles; no stage skipped; done after 17 cycles.
- Continuous en with instant dones → runs repeat every 18 cycles; run_count increments each run; en pulse while busy has no effect.
- nrst low during stage 3 WAIT → next cycle all outputs 0, run_count=0, no pulses; a fresh en then restarts at stage 0.

Source files
------------

// File: rtl/stage_sequencer_if.sv
// Handshake bundle between the stage sequencer and the per-packet stage chain.
//   master : the sequencer (samples en/stage_done/abort_req, drives starts,
//            clear, mux selects, write gate, status and end-of-run pulses)
//   slave  : the run requester / stage side (drives en, stage_done, abort_req)
interface stage_sequencer_if #(
  parameter int unsigned NUM_STAGES = 8,
  parameter int unsigned SEL_W      = 3
);
  logic                  en;
  logic [NUM_STAGES-1:0] stage_done;
  logic [NUM_STAGES-1:0] abort_req;
  logic [NUM_STAGES-1:0] stage_start;
  logic                  stage_clr;
  logic [SEL_W-1:0]      addr_select;
  logic [SEL_W-1:0]      wr_select;
  logic                  wr_allow;
  logic                  busy;
  logic                  done;
  logic                  aborted;
  logic                  timeout;
  logic [SEL_W-1:0]      end_stage;
  logic [15:0]           run_count;

  modport master (
    input  en, stage_done, abort_req,
    output stage_start, stage_clr, addr_select, wr_select, wr_allow,
           busy, done, aborted, timeout, end_stage, run_count
  );

  modport slave (
    output en, stage_done, abort_req,
    input  stage_start, stage_clr, addr_select, wr_select, wr_allow,
           busy, done, aborted, timeout, end_stage, run_count
  );
endinterface

// File: rtl/stage_sequencer.sv
// Registered run controller for the stage chain sharing the node memory.
// Starts each stage with a one-cycle pulse, waits for its level done flag,
// steers the memory address/data and write-enable muxes to the current
// stage, gates writes for read-only stages and ends a run on completion,
// on a stage's abort request or on a per-stage watchdog expiry.
// Ports:
//   clock : rising-edge clock
//   nrst  : synchronous active-low reset
//   bus   : stage_sequencer_if.master (en, stage_done, abort_req in;
//           stage_start, stage_clr, addr_select, wr_select, wr_allow, busy,
//           done, aborted, timeout, end_stage, run_count out)
module stage_sequencer #(
  parameter int unsigned           NUM_STAGES = 8,
  parameter int unsigned           SEL_W      = 3,
  parameter int unsigned           TIMEOUT    = 2000,
  parameter logic [NUM_STAGES-1:0] WRITE_MASK = 8'b1010_1111
) (
  input logic clock,
  input logic nrst,
  stage_sequencer_if.master bus
);

  localparam int unsigned     WD_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_LAST  = WD_W'(TIMEOUT - 1);
  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_STAGES - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_CLEAR} state_t;
  typedef enum logic [1:0] {C_DONE, C_ABORT, C_TIMEOUT} cause_t;

  state_t           state_q, state_d;
  cause_t           cause_q, cause_d;
  logic [SEL_W-1:0] idx_q, idx_d;
  logic [WD_W-1:0]  wd_q, wd_d;
  logic [SEL_W-1:0] end_stage_q, end_stage_d;
  logic [15:0]      run_count_q, run_count_d;

  always_ff @(posedge clock) begin
    if (!nrst) begin
      state_q     <= S_IDLE;
      cause_q     <= C_DONE;
      idx_q       <= '0;
      wd_q        <= '0;
      end_stage_q <= '0;
      run_count_q <= '0;
    end else begin
      state_q     <= state_d;
      cause_q     <= cause_d;
      idx_q       <= idx_d;
      wd_q        <= wd_d;
      end_stage_q <= end_stage_d;
      run_count_q <= run_count_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cause_d     = cause_q;
    idx_d       = idx_q;
    wd_d        = wd_q;
    end_stage_d = end_stage_q;
    run_count_d = run_count_q;
    case (state_q)
      S_IDLE: begin
        if (bus.en) begin
          state_d = S_START;
          idx_d   = '0;
        end
      end
      // stage_done is deliberately not looked at here, so a done flag left
      // high by a not-yet-cleared stage cannot skip the stage just started.
      S_START: begin
        wd_d    = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A done on the expiry cycle takes precedence over the watchdog.
        if (bus.stage_done[idx_q]) begin
          if (bus.abort_req[idx_q]) begin
            state_d     = S_CLEAR;
            cause_d     = C_ABORT;
            end_stage_d = idx_q;
          end else if (idx_q == LAST_IDX) begin
            state_d     = S_CLEAR;
            cause_d     = C_DONE;
            end_stage_d = idx_q;
            run_count_d = run_count_q + 16'd1;
          end else begin
            state_d = S_START;
            idx_d   = idx_q + 1'b1;
          end
        end else if (wd_q == WD_LAST) begin
          state_d     = S_CLEAR;
          cause_d     = C_TIMEOUT;
          end_stage_d = idx_q;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      S_CLEAR: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  logic active;
  logic clearing;
  assign active   = (state_q == S_START) || (state_q == S_WAIT);
  assign clearing = (state_q == S_CLEAR);

  assign bus.stage_start = (state_q == S_START) ? (NUM_STAGES'(1) << idx_q) : '0;
  assign bus.stage_clr   = clearing;
  assign bus.addr_select = active ? idx_q : '0;
  assign bus.wr_select   = active ? idx_q : '0;
  assign bus.wr_allow    = active && WRITE_MASK[idx_q];
  assign bus.busy        = (state_q != S_IDLE);
  assign bus.done        = clearing && (cause_q == C_DONE);
  assign bus.aborted     = clearing && (cause_q == C_ABORT);
  assign bus.timeout     = clearing && (cause_q == C_TIMEOUT);
  assign bus.end_stage   = end_stage_q;
  assign bus.run_count   = run_count_q;

endmodule

// File: tb/tb_stage_sequencer.sv
// Self-checking bench for stage_sequencer: emulates the stage chain, predicts
// the per-cycle output timeline of each run from per-stage wait lengths, and
// compares every cycle; literal latency/end-state checks pin the predictor.
module tb_stage_sequencer;
  localparam int unsigned T = 16;
  localparam logic [7:0]  WMASK = 8'b1010_1111;

  logic clock = 1'b0;
  logic nrst  = 1'b0;
  always #5 clock = ~clock;

  stage_sequencer_if #(.NUM_STAGES(8), .SEL_W(3)) bus ();

  stage_sequencer #(
    .NUM_STAGES(8),
    .SEL_W(3),
    .TIMEOUT(T),
    .WRITE_MASK(WMASK)
  ) dut (
    .clock(clock),
    .nrst(nrst),
    .bus(bus)
  );

  typedef struct {
    logic [7:0]  start;
    logic        clr;
    logic [2:0]  sel;
    logic        wr;
    logic        busy;
    logic        dn;
    logic        ab;
    logic        to;
    logic [2:0]  es;
    logic [15:0] rc;
  } exp_t;

  exp_t q[$];
  logic [2:0]  m_es = '0;
  logic [15:0] m_rc = '0;

  // scenario: sc_d[i] = WAIT cycle on which stage i shows done (0 = never)
  int unsigned sc_d [8];
  bit          sc_ab[8];
  bit          sc_stale = 1'b0;
  int unsigned ctr  [8];

  int unsigned tests = 0;
  int unsigned fails = 0;
  int unsigned cyc   = 0;
  bit          cur_idle;
  int unsigned en_cyc = 0;
  int          last_lat = -1;
  int          last_kind = 0;
  int unsigned start_cnt[8];
  int unsigned last_s0 = 0, prev_s0 = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t idle_rec();
    exp_t r;
    r.start = '0; r.clr = 1'b0; r.sel = '0; r.wr = 1'b0; r.busy = 1'b0;
    r.dn = 1'b0; r.ab = 1'b0; r.to = 1'b0; r.es = m_es; r.rc = m_rc;
    return r;
  endfunction

  // Expand one run into its cycle-by-cycle expected outputs.
  task automatic push_run();
    exp_t        r;
    bit          fin;
    int unsigned w;
    int          ending;
    ending = 0;
    for (int i = 0; i < 8 && ending == 0; i++) begin
      r       = idle_rec();
      r.busy  = 1'b1;
      r.sel   = 3'(i);
      r.wr    = WMASK[i];
      r.start = 8'd1 << i;
      q.push_back(r);
      r.start = '0;
      fin = sc_stale || (sc_d[i] != 0 && sc_d[i] <= T);
      w   = sc_stale ? 1 : (fin ? sc_d[i] : T);
      repeat (w) q.push_back(r);
      if (!fin) ending = 3;
      else if (!sc_stale && sc_ab[i]) ending = 2;
      else if (i == 7) ending = 1;
      if (ending != 0) begin
        m_es = 3'(i);
        if (ending == 1) m_rc = m_rc + 16'd1;
        r      = idle_rec();
        r.busy = 1'b1;
        r.clr  = 1'b1;
        r.dn   = (ending == 1);
        r.ab   = (ending == 2);
        r.to   = (ending == 3);
        q.push_back(r);
      end
    end
  endtask

  task automatic tick(input bit e_in, input bit r_in);
    exp_t e;
    @(negedge clock);
    cyc++;
    cur_idle = (q.size() == 0);
    e = cur_idle ? idle_rec() : q.pop_front();
    chk("stage_start", 32'(bus.stage_start), 32'(e.start));
    chk("stage_clr",   32'(bus.stage_clr),   32'(e.clr));
    chk("addr_select", 32'(bus.addr_select), 32'(e.sel));
    chk("wr_select",   32'(bus.wr_select),   32'(e.sel));
    chk("wr_allow",    32'(bus.wr_allow),    32'(e.wr));
    chk("busy",        32'(bus.busy),        32'(e.busy));
    chk("done",        32'(bus.done),        32'(e.dn));
    chk("aborted",     32'(bus.aborted),     32'(e.ab));
    chk("timeout",     32'(bus.timeout),     32'(e.to));
    chk("end_stage",   32'(bus.end_stage),   32'(e.es));
    chk("run_count",   32'(bus.run_count),   32'(e.rc));
    // observations for the literal checks
    if (bus.done === 1'b1 || bus.aborted === 1'b1 || bus.timeout === 1'b1) begin
      last_lat  = int'(cyc - en_cyc);
      last_kind = (bus.done === 1'b1) ? 1 : (bus.aborted === 1'b1) ? 2 : 3;
    end
    for (int i = 0; i < 8; i++) if (bus.stage_start[i] === 1'b1) start_cnt[i]++;
    if (bus.stage_start[0] === 1'b1) begin
      prev_s0 = last_s0;
      last_s0 = cyc;
    end
    // stage chain emulation
    if (sc_stale) begin
      bus.stage_done = '1;
      bus.abort_req  = '0;
    end else if (bus.stage_clr === 1'b1) begin
      bus.stage_done = '0;
      bus.abort_req  = '0;
      for (int i = 0; i < 8; i++) ctr[i] = 0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (bus.stage_start[i] === 1'b1) ctr[i] = sc_d[i];
        else if (ctr[i] > 0) begin
          ctr[i]--;
          if (ctr[i] == 0) begin
            bus.stage_done[i] = 1'b1;
            bus.abort_req[i]  = sc_ab[i];
          end
        end
        if (bus.stage_done[i] == 1'b0) bus.abort_req[i] = 1'($urandom % 2);
      end
    end
    bus.en = e_in;
    nrst   = r_in;
    if (!r_in) begin
      q.delete();
      m_es = '0;
      m_rc = '0;
      bus.stage_done = '0;
      bus.abort_req  = '0;
      for (int i = 0; i < 8; i++) ctr[i] = 0;
    end else if (e_in && cur_idle) begin
      push_run();
      en_cyc = cyc;
    end
  endtask

  task automatic set_all(input int unsigned d);
    for (int i = 0; i < 8; i++) begin
      sc_d[i]  = d;
      sc_ab[i] = 1'b0;
      start_cnt[i] = 0;
    end
    last_lat  = -1;
    last_kind = 0;
  endtask

  task automatic drain();
    for (int n = 0; n < 400 && q.size() != 0; n++) tick(1'b0, 1'b1);
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b1);
  endtask

  initial begin
    bus.en = 1'b0;
    bus.stage_done = '0;
    bus.abort_req  = '0;
    set_all(2);
    repeat (3) tick(1'b0, 1'b0);
    tick(1'b0, 1'b1);
    chk("reset_run_count", 32'(bus.run_count), 32'd0);

    // normal run, w_i = 2
    set_all(2);
    tick(1'b1, 1'b1);
    drain();
    chk("normal_latency", 32'(last_lat), 32'd25);
    chk("normal_kind",    32'(last_kind), 32'd1);
    chk("normal_end_stage", 32'(bus.end_stage), 32'd7);
    chk("normal_run_count", 32'(bus.run_count), 32'd1);
    for (int i = 0; i < 8; i++) chk("normal_start_count", start_cnt[i], 32'd1);

    // abort at stage 1
    set_all(2);
    sc_ab[1] = 1'b1;
    tick(1'b1, 1'b1);
    drain();
    chk("abort_latency", 32'(last_lat), 32'd7);
    chk("abort_kind",    32'(last_kind), 32'd2);
    chk("abort_end_stage", 32'(bus.end_stage), 32'd1);
    chk("abort_no_start2", start_cnt[2], 32'd0);
    chk("abort_run_count", 32'(bus.run_count), 32'd1);

    // watchdog at stage 4
    set_all(1);
    sc_d[4] = 0;
    tick(1'b1, 1'b1);
    drain();
    chk("timeout_latency", 32'(last_lat), 32'd26);
    chk("timeout_kind",    32'(last_kind), 32'd3);
    chk("timeout_end_stage", 32'(bus.end_stage), 32'd4);

    // done on the watchdog expiry cycle wins
    set_all(1);
    sc_d[5] = T;
    tick(1'b1, 1'b1);
    drain();
    chk("expiry_done_kind", 32'(last_kind), 32'd1);
    chk("expiry_run_count", 32'(bus.run_count), 32'd2);

    // stale dones held high throughout
    set_all(1);
    sc_stale = 1'b1;
    bus.stage_done = '1;
    bus.abort_req  = '0;
    tick(1'b1, 1'b1);
    drain();
    chk("stale_latency", 32'(last_lat), 32'd17);
    for (int i = 0; i < 8; i++) chk("stale_start_count", start_cnt[i], 32'd1);
    sc_stale = 1'b0;
    bus.stage_done = '0;
    tick(1'b0, 1'b1);

    // continuous en, instant dones: three back-to-back runs
    set_all(1);
    for (int n = 0; n < 40; n++) tick(1'b1, 1'b1);
    drain();
    chk("b2b_period", last_s0 - prev_s0, 32'd18);
    chk("b2b_run_count", 32'(bus.run_count), 32'd6);
    chk("b2b_start0_count", start_cnt[0], 32'd3);

    // reset during stage 3 WAIT
    set_all(3);
    tick(1'b1, 1'b1);
    while (cyc < en_cyc + 14) tick(1'b0, 1'b1);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    chk("rst_run_count", 32'(bus.run_count), 32'd0);
    chk("rst_busy",      32'(bus.busy), 32'd0);
    chk("rst_start",     32'(bus.stage_start), 32'd0);
    tick(1'b0, 1'b1);
    set_all(2);
    tick(1'b1, 1'b1);
    drain();
    chk("post_rst_latency", 32'(last_lat), 32'd25);
    chk("post_rst_run_count", 32'(bus.run_count), 32'd1);

    // randomized runs with en noise while busy
    for (int n = 0; n < 2500; n++) begin
      if (q.size() == 0) begin
        for (int i = 0; i < 8; i++) begin
          sc_d[i]  = ($urandom_range(0, 29) == 0) ? 0 : $urandom_range(1, 18);
          sc_ab[i] = ($urandom_range(0, 11) == 0);
        end
      end
      tick(1'($urandom_range(0, 3) == 0), 1'b1);
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
